// File: rtl/lcd_spi_pixel_tx_pkg.sv
// Shared types and constants for the RGB565 SPI panel transmitter.
// Holds the FSM encoding, SPI framing constants and default geometry.
package lcd_spi_pixel_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_PIX,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int   BITS_PER_PIX = 16;
  localparam logic SCLK_IDLE    = 1'b0;
  localparam logic DC_DATA      = 1'b1;

  localparam int DEF_H_PIX   = 240;
  localparam int DEF_V_PIX   = 240;
  localparam int DEF_CLK_DIV = 2;

  // counter width that stays legal for a range of one
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_spi_pixel_tx_if.sv
// Pixel stream handshake plus raster position fed back upstream.
// master = renderer side, slave = transmitter side.
interface lcd_spi_pixel_tx_if #(
  parameter int XW = 8,
  parameter int YW = 8
);
  logic [15:0]   iPixel;
  logic          iValid;
  logic          oReady;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;

  modport master (
    output iPixel,
    output iValid,
    input  oReady,
    input  oX,
    input  oY
  );

  modport slave (
    input  iPixel,
    input  iValid,
    output oReady,
    output oX,
    output oY
  );
endinterface

// File: rtl/lcd_spi_pixel_tx_shifter.sv
// Mode-0 SPI serialiser: SCLK divider, 16-bit shift register, bit count.
// o_last flags the cycle whose edge produces the final falling SCLK.
module lcd_spi_shifter
  import lcd_spi_pixel_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic [BITS_PER_PIX-1:0] i_data,
  input  logic                    i_clr,
  output logic                    o_sclk,
  output logic                    o_mosi,
  output logic                    o_last
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam int BW = cnt_w(BITS_PER_PIX);

  logic                    r_active;
  logic [DW-1:0]           r_div;
  logic [BW-1:0]           r_bits;
  logic [BITS_PER_PIX-1:0] r_sr;
  logic                    r_sclk;
  logic                    r_mosi;

  logic w_tick;
  logic w_fall;

  assign w_tick = r_active && (r_div == DW'(CLK_DIV - 1));
  assign w_fall = w_tick && r_sclk;
  assign o_last = w_fall && (r_bits == BW'(BITS_PER_PIX - 1));

  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bits   <= '0;
      r_sr     <= '0;
      r_sclk   <= SCLK_IDLE;
      r_mosi   <= 1'b0;
    end else if (i_load && !r_active) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bits   <= '0;
      r_sclk   <= SCLK_IDLE;
      r_mosi   <= i_data[BITS_PER_PIX-1];
      r_sr     <= {i_data[BITS_PER_PIX-2:0], 1'b0};
    end else if (r_active) begin
      if (w_tick) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else begin
          r_sclk <= SCLK_IDLE;
          r_bits <= r_bits + BW'(1);
          // final bit stays on MOSI after the last fall
          if (o_last) begin
            r_active <= 1'b0;
          end else begin
            r_mosi <= r_sr[BITS_PER_PIX-1];
            r_sr   <= {r_sr[BITS_PER_PIX-2:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end else if (i_clr) begin
      r_mosi <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_spi_pixel_tx.sv
// Frame-level RGB565 to SPI panel transmitter: FSM, raster, CS/DC.
// One chip-select window carries a whole H_PIX x V_PIX screen.
module lcd_spi_pixel_tx
  import lcd_spi_pixel_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_PIX   = DEF_V_PIX
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     iEn,
  lcd_spi_pixel_tx_if.slave        pix,
  output logic                     oSclk,
  output logic                     oMosi,
  output logic                     oCs_n,
  output logic                     oDc,
  output logic                     oBusy,
  output logic                     oFrameDone
);

  localparam int XW = cnt_w(H_PIX);
  localparam int YW = cnt_w(V_PIX);

  state_t        r_state;
  logic          r_cs_n;
  logic          r_busy;
  logic          r_done;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic w_ready;
  logic w_load;
  logic w_clr;
  logic w_last;
  logic w_eol;
  logic w_eof;

  assign w_ready = (r_state == ST_WAIT_PIX);
  assign w_load  = w_ready && pix.iValid;
  assign w_clr   = (r_state == ST_DONE);
  assign w_eol   = (r_x == XW'(H_PIX - 1));
  assign w_eof   = w_eol && (r_y == YW'(V_PIX - 1));

  lcd_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .i_load (w_load),
    .i_data (pix.iPixel),
    .i_clr  (w_clr),
    .o_sclk (oSclk),
    .o_mosi (oMosi),
    .o_last (w_last)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (iEn) r_state <= ST_START;
        end
        ST_START: begin
          r_cs_n  <= 1'b0;
          r_busy  <= 1'b1;
          r_x     <= '0;
          r_y     <= '0;
          r_state <= ST_WAIT_PIX;
        end
        ST_WAIT_PIX: begin
          if (pix.iValid) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last) begin
            if (w_eof) begin
              r_x     <= '0;
              r_y     <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else if (w_eol) begin
              r_x     <= '0;
              r_y     <= r_y + YW'(1);
              r_state <= ST_WAIT_PIX;
            end else begin
              r_x     <= r_x + XW'(1);
              r_state <= ST_WAIT_PIX;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pix.oReady = w_ready;
  assign pix.oX     = r_x;
  assign pix.oY     = r_y;
  assign oCs_n      = r_cs_n;
  assign oDc        = DC_DATA;
  assign oBusy      = r_busy;
  assign oFrameDone = r_done;

endmodule

// File: tb/tb_lcd_spi_pixel_tx.sv
// Randomised bench for lcd_spi_pixel_tx on a 4x2 panel, CLK_DIV=2.
// A timeline model predicts every output each cycle.
module tb_lcd_spi_pixel_tx;

  localparam int CD = 2;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int XW = (H > 1) ? $clog2(H) : 1;
  localparam int YW = (V > 1) ? $clog2(V) : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic oSclk, oMosi, oCs_n, oDc, oBusy, oFrameDone;

  always #5 clk = ~clk;

  lcd_spi_pixel_tx_if #(.XW(XW), .YW(YW)) pif ();

  lcd_spi_pixel_tx #(
    .CLK_DIV (CD),
    .H_PIX   (H),
    .V_PIX   (V)
  ) u_dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .iEn        (en),
    .pix        (pif),
    .oSclk      (oSclk),
    .oMosi      (oMosi),
    .oCs_n      (oCs_n),
    .oDc        (oDc),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: phase 0 idle,1 start,2 wait,3 shift,4 done
  int          m_ph = 0;
  int          m_t = 0;
  int          m_x = 0;
  int          m_y = 0;
  logic [15:0] m_pix = '0;
  logic        m_cs = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_fd = 1'b0;
  logic        m_hold = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_t = 0; m_x = 0; m_y = 0;
      m_cs = 1'b1; m_busy = 1'b0; m_fd = 1'b0; m_hold = 1'b0;
    end else begin
      case (m_ph)
        0: if (en) m_ph = 1;
        1: begin
          m_ph = 2; m_cs = 1'b0; m_busy = 1'b1; m_x = 0; m_y = 0;
        end
        2: if (pif.iValid) begin
          m_pix = pif.iPixel; m_t = 0; m_ph = 3;
        end
        3: begin
          m_t++;
          if (m_t == 32 * CD) begin
            int idx;
            m_hold = m_pix[0];
            idx = m_y * H + m_x + 1;
            if (idx == H * V) begin
              m_x = 0; m_y = 0; m_fd = 1'b1; m_ph = 4;
            end else begin
              m_x = idx % H; m_y = idx / H; m_ph = 2;
            end
          end
        end
        4: begin
          m_fd = 1'b0; m_cs = 1'b1; m_busy = 1'b0; m_hold = 1'b0; m_ph = 0;
        end
        default: m_ph = 0;
      endcase
    end
  end

  // compare + monitor
  logic        cmp_en = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_fd = 1'b0;
  logic [15:0] cap = '0;
  int          rises = 0;
  int          fd_cnt = 0;
  int          cs_falls = 0;
  int          ncyc = 0;
  int          fd_cyc = 0;
  int          cs_rise_cyc = 0;
  int          cs_fall_cyc = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      int es;
      int em;
      es = (m_ph == 3) ? (m_t / CD) % 2 : 0;
      em = (m_ph == 3) ? 32'(m_pix[15 - m_t / (2 * CD)]) : 32'(m_hold);
      chk("sclk", 32'(oSclk), es);
      chk("mosi", 32'(oMosi), em);
      chk("cs_n", 32'(oCs_n), 32'(m_cs));
      chk("dc", 32'(oDc), 1);
      chk("busy", 32'(oBusy), 32'(m_busy));
      chk("frame_done", 32'(oFrameDone), 32'(m_fd));
      chk("ready", 32'(pif.oReady), (m_ph == 2) ? 1 : 0);
      chk("x", 32'(pif.oX), m_x);
      chk("y", 32'(pif.oY), m_y);
    end
    if (oSclk === 1'b1 && prev_sclk === 1'b0) begin
      rises++;
      cap = {cap[14:0], oMosi};
    end
    if (oFrameDone === 1'b1 && prev_fd === 1'b0) begin
      fd_cnt++;
      fd_cyc = ncyc;
    end
    if (oCs_n === 1'b1 && prev_cs === 1'b0) cs_rise_cyc = ncyc;
    if (oCs_n === 1'b0 && prev_cs === 1'b1) begin
      cs_falls++;
      cs_fall_cyc = ncyc;
    end
    prev_sclk = oSclk;
    prev_fd = oFrameDone;
    prev_cs = oCs_n;
    ncyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int tx_i = 0;

  task automatic send_pixel(input logic [15:0] p, input int gap);
    int w;
    w = 0;
    while (!pif.oReady && w < 600) begin
      tick();
      w++;
    end
    chk("ready_wait", 32'(pif.oReady), 1);
    for (int g = 0; g < gap; g++) begin
      pif.iValid = 1'b0;
      pif.iPixel = 16'($urandom);
      tick();
    end
    chk("tx_x", 32'(pif.oX), tx_i % H);
    chk("tx_y", 32'(pif.oY), tx_i / H);
    pif.iValid = 1'b1;
    pif.iPixel = p;
    tick();
    pif.iValid = 1'($urandom);
    pif.iPixel = 16'($urandom);
    tx_i++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int w;
    int lows;
    pif.iValid = 1'b1;
    pif.iPixel = 16'hFFFF;
    en = 1'b1;
    rst_n = 1'b0;
    tick();
    cmp_en = 1'b1;
    repeat (4) tick();
    chk("rst_rises", rises, 0);
    chk("rst_cs", 32'(oCs_n), 1);
    rst_n = 1'b1;
    pif.iValid = 1'b0;

    // frame A: known first pixel, backpressure, then random
    tx_i = 0;
    r0 = rises;
    send_pixel(16'hD69A, 0);
    pif.iValid = 1'b0;
    lows = 0;
    while (!pif.oReady && lows < 200) begin
      tick();
      lows++;
    end
    chk("xfer_cycles", lows, 64);
    chk("p0_rises", rises - r0, 16);
    chk("p0_bits", 32'(cap), 32'hD69A);
    chk("p0_x", 32'(pif.oX), 1);
    chk("p0_y", 32'(pif.oY), 0);

    r0 = rises;
    for (int i = 0; i < 10; i++) begin
      pif.iValid = 1'b0;
      pif.iPixel = 16'($urandom);
      tick();
      chk("bp_ready", 32'(pif.oReady), 1);
      chk("bp_sclk", 32'(oSclk), 0);
      chk("bp_cs", 32'(oCs_n), 0);
    end
    chk("bp_rises", rises - r0, 0);

    for (int i = 1; i < H * V; i++)
      send_pixel(16'($urandom), $urandom_range(0, 3));
    pif.iValid = 1'b0;
    w = 0;
    while (fd_cnt == 0 && w < 300) begin
      tick();
      w++;
    end
    chk("fd_a", fd_cnt, 1);
    w = 0;
    while (cs_falls < 2 && w < 50) begin
      tick();
      w++;
    end
    chk("fd_to_cs", cs_rise_cyc - fd_cyc, 1);
    chk("cs_gap", cs_fall_cyc - cs_rise_cyc, 2);

    // frame B: enable dropped after three pixels
    tx_i = 0;
    for (int i = 0; i < H * V; i++) begin
      send_pixel(16'($urandom), $urandom_range(0, 2));
      if (i == 2) en = 1'b0;
    end
    pif.iValid = 1'b0;
    w = 0;
    while (fd_cnt < 2 && w < 300) begin
      tick();
      w++;
    end
    repeat (30) tick();
    chk("fd_b", fd_cnt, 2);
    chk("no_restart", cs_falls, 2);
    chk("b_cs", 32'(oCs_n), 1);
    chk("b_busy", 32'(oBusy), 0);

    // reset during bit 7 of a pixel
    en = 1'b1;
    tx_i = 0;
    send_pixel(16'($urandom), 0);
    repeat (29) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_sclk", 32'(oSclk), 0);
    chk("rst_cs_mid", 32'(oCs_n), 1);
    chk("rst_x", 32'(pif.oX), 0);
    chk("rst_y", 32'(pif.oY), 0);
    chk("rst_busy", 32'(oBusy), 0);
    rst_n = 1'b1;
    tx_i = 0;
    r0 = rises;
    send_pixel(16'h1234, 1);
    pif.iValid = 1'b0;
    w = 0;
    while (!pif.oReady && w < 200) begin
      tick();
      w++;
    end
    chk("rr_bits", 32'(cap), 32'h1234);
    chk("rr_rises", rises - r0, 16);
    chk("rr_x", 32'(pif.oX), 1);
    en = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_spi_pixel_tx.md
Name: lcd_spi_pixel_tx

Overview:
Downstream consumer of the 16-bit RGB565 pixel stream produced by the colour-conversion stage.
- Accepts one pixel at a time over a valid/ready handshake and serialises it MSB-first as two bytes on a mode-0 SPI link to the panel.
- Walks a raster counter (oX, oY) so the upstream renderer knows which pixel to supply next.
- Frames one full H_PIX x V_PIX screen per chip-select window.

Parameters:
CLK_DIV, 2, SCLK half-period in sys_clk cycles (minimum 1; SCLK = sys_clk / (2*CLK_DIV))
H_PIX, 240, pixels per line
V_PIX, 240, lines per frame

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  synchronous reset, active-low
iEn  input  1  level; sampled in IDLE to start a frame
iPixel  input  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
iValid  input  1  iPixel valid
oReady  output  1  block can accept a pixel this cycle
oX  output  $clog2(H_PIX)  column of the pixel being requested or sent
oY  output  $clog2(V_PIX)  row of the pixel being requested or sent
oSclk  output  1  SPI clock, idles low
oMosi  output  1  SPI data, MSB first
oCs_n  output  1  panel chip select, active-low
oDc  output  1  data/command select; constant 1 (pixel data)
oBusy  output  1  high from frame start until oCs_n returns high
oFrameDone  output  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (sys_rst_n low at an edge): oSclk=0, oMosi=0, oCs_n=1, oDc=1, oReady=0, oBusy=0, oFrameDone=0, oX=0, oY=0, state=IDLE, divider and bit counters cleared.
- Reset mid-frame aborts immediately. There is no partial-pixel completion.
- The FSM states are IDLE, START, WAIT_PIX, SHIFT, DONE.
- IDLE: outputs at idle values. If iEn=1 -> START.
- START: one cycle. oCs_n=0, oBusy=1, oX=oY=0 -> WAIT_PIX. This gives one sys_clk of CS setup before the first SCLK edge.
- WAIT_PIX:
  - oReady=1 (combinational decode of state). oSclk=0. oMosi holds the last value.
  - Transfer happens when iValid && oReady: load a 16-bit shift register with iPixel, drive oMosi=iPixel[15] from the next cycle -> SHIFT.
  - If iValid=0, stay; oCs_n stays low and SCLK stays idle indefinitely.
- SHIFT:
  - Divider counts CLK_DIV sys_clk cycles per SCLK phase.
  - Low phase elapses -> oSclk rises (panel samples).
  - High phase elapses -> oSclk falls and the next bit is shifted onto oMosi on that same edge.
  - After the 16th falling edge:
    - Advance the raster. If oX==H_PIX-1: oX=0 and oY+=1, else oX+=1.
    - If the pixel just sent was (H_PIX-1, V_PIX-1) -> DONE, else -> WAIT_PIX.
  - Cost is 32*CLK_DIV cycles per pixel plus at least 1 WAIT_PIX cycle.
- DONE: one cycle. oCs_n=1, oBusy=0, oFrameDone=1, oX=oY=0 -> IDLE.
  - If iEn is still high, the next frame starts after one IDLE cycle, so CS is high for at least 2 cycles between frames.
- iEn is ignored outside IDLE. Deasserting it mid-frame does not stop the frame.
- iPixel is not used outside the transfer cycle. Pixel content is passed unmodified (no colour remap).
- oX/oY never exceed H_PIX-1 / V_PIX-1. The counters wrap only via the raster rule above.

Decomposition:
- Shared visual package holds:
  - the FSM state enum;
  - the SPI constants (bits per pixel = 16, SCLK idle level = 0, DC_DATA = 1);
  - default panel geometry (240x240).
- One natural sub-module is lcd_spi_shifter: divider + 16-bit shift register + bit counter, with load/done handshake. The top level keeps the FSM, raster counters and CS/DC control.

Test Plan:
- Reset hold with iEn=1, iValid=1 -> all outputs at reset values; oCs_n=1, oSclk=0, no SCLK edges.
- CLK_DIV=2, single pixel 0xD69A:
  - oMosi sampled on oSclk rising edges reads 1101_0110_1001_1010;
  - exactly 16 rising edges;
  - 64 cycles from transfer to return to WAIT_PIX;
  - oX goes 0->1.
- Backpressure: iValid low for 10 cycles between pixels -> oReady stays 1, oSclk stays 0, oCs_n stays 0, no extra edges; the next pixel then sends normally.
- H_PIX=4, V_PIX=2:
  - oX/oY sequence is (0,0)(1,0)(2,0)(3,0)(0,1)..(3,1);
  - oFrameDone pulses once, one cycle after the 8th pixel's last falling edge;
  - oCs_n high 1 cycle later, with oBusy falling together.
- iEn dropped after 3 pixels of a frame -> frame still completes all H_PIX*V_PIX pixels; no restart follows. With iEn held high, the next frame's oCs_n falls 2 cycles after the oCs_n rise.
- sys_rst_n pulled low during bit 7 of a pixel -> next edge gives oSclk=0, oCs_n=1, oX=oY=0, state IDLE. A new frame after release starts at (0,0) with a full 16-bit transfer.
